// File: rtl/sync_fifo.sv
// sync_fifo: parameterised single-clock queue with optional
// empty bypass (FLOW) and enqueue-on-full pass-through (PIPE).
module sync_fifo #(
  parameter int WIDTH        = 64,
  parameter int DEPTH        = 4,
  parameter int FLOW         = 0,
  parameter int PIPE         = 0,
  parameter int AFULL_THRESH = DEPTH - 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_bits,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_bits,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam bit FLOW_B = (FLOW != 0);
  localparam bit PIPE_B = (PIPE != 0);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] AF   = CW'(AFULL_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             maybe_full;
  logic [CW-1:0]    cnt;

  logic ptr_eq;
  logic empty;
  logic full;
  logic hold;
  logic enq_fire;
  logic deq_fire;
  logic bypass;
  logic do_enq;
  logic do_deq;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign ptr_eq = (rd_ptr == wr_ptr);
  assign empty  = ptr_eq & ~maybe_full;
  assign full   = ptr_eq & maybe_full;
  assign hold   = reset | flush;

  assign enq_ready = ~hold & (~full | (PIPE_B & deq_ready));
  assign deq_valid = ~hold & (~empty | (FLOW_B & enq_valid));
  assign deq_bits  = (FLOW_B & empty) ? enq_bits : mem[rd_ptr];

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = deq_valid & deq_ready;

  // Bypassed beats go straight through and never touch storage.
  assign bypass = FLOW_B & empty & deq_fire;
  assign do_enq = enq_fire & ~bypass;
  assign do_deq = deq_fire & ~empty;

  assign count       = cnt;
  assign almost_full = (cnt >= AF);

  always_ff @(posedge clock) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_bits;
    end
  end

  always_ff @(posedge clock) begin
    if (hold) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      maybe_full <= 1'b0;
      cnt        <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_deq) begin
        rd_ptr <= bump(rd_ptr);
      end
      if (do_enq & ~do_deq) begin
        maybe_full <= 1'b1;
        cnt        <= cnt + 1'b1;
      end else if (do_deq & ~do_enq) begin
        maybe_full <= 1'b0;
        cnt        <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter WIDTH, default 64: payload width in bits, SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: entry count, SHALL accept any integer >= 1, not only powers of two.
REQ-003 Parameter FLOW, default 0: 1 SHALL enable empty-queue combinational bypass, enq to deq.
REQ-004 Parameter PIPE, default 0: 1 SHALL allow enqueue when full if a dequeue fires in the same cycle.
REQ-005 Parameter AFULL_THRESH, default DEPTH-1: almost_full threshold, SHALL satisfy 1 <= AFULL_THRESH <= DEPTH.
REQ-006 clock  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 flush  input  1  synchronous discard of all stored entries.
REQ-009 enq_valid  input  1  producer offers enq_bits.
REQ-010 enq_ready  output  1  queue accepts enq_bits this cycle.
REQ-011 enq_bits  input  WIDTH  enqueue payload.
REQ-012 deq_valid  output  1  deq_bits holds a valid entry.
REQ-013 deq_ready  input  1  consumer takes deq_bits this cycle.
REQ-014 deq_bits  output  WIDTH  dequeue payload, oldest entry first.
REQ-015 count  output  clog2(DEPTH+1)  number of stored entries, 0..DEPTH.
REQ-016 almost_full  output  1  high when count >= AFULL_THRESH.

Function
REQ-017 enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
REQ-018 Read/write pointers SHALL range 0..DEPTH-1 and wrap from DEPTH-1 to 0; full/empty disambiguated by a registered maybe_full flag, set on enq-only, cleared on deq-only.
REQ-019 empty = (rd_ptr == wr_ptr) & !maybe_full; full = (rd_ptr == wr_ptr) & maybe_full.
REQ-020 enq_ready = !full | (PIPE & deq_ready), forced 0 while reset or flush is high.
REQ-021 deq_valid = !empty | (FLOW & enq_valid), forced 0 while reset or flush is high.
REQ-022 deq_bits = mem[rd_ptr] when not empty; = enq_bits when FLOW and empty.
REQ-023 Latency without bypass: entry enqueued at edge N SHALL present deq_valid=1 in cycle N+1.
REQ-024 FLOW bypass: empty & enq_valid & deq_ready SHALL pass data in the same cycle, no write to storage, pointers and count unchanged.
REQ-025 Simultaneous enq_fire and deq_fire (non-bypass): both pointers advance, count and maybe_full unchanged.
REQ-026 count SHALL be +1 on enq-only, -1 on deq-only, unchanged otherwise; never exceeds DEPTH nor drops below 0.
REQ-027 Order SHALL be strict FIFO; no entry lost or duplicated.
REQ-028 While deq_valid & !deq_ready and queue non-empty, deq_bits SHALL remain stable.
REQ-029 flush high at edge N SHALL make count=0, pointers=0, maybe_full=0 in cycle N+1; enqueue offered in cycle N is dropped.
REQ-030 almost_full SHALL be combinational from count.
REQ-031 DEPTH=1 SHALL behave as single-entry mailbox: enq_ready=!full (or PIPE rule), one-cycle latency.

Reset
REQ-032 reset high at an edge SHALL set rd_ptr=0, wr_ptr=0, maybe_full=0, count=0.
REQ-033 Out of reset: enq_ready=1, deq_valid=0 (or enq_valid if FLOW), count=0, almost_full=0 (AFULL_THRESH>=1).
REQ-034 Storage contents SHALL NOT be reset; deq_bits is don't-care while deq_valid=0.
REQ-035 reset asserted mid-operation SHALL discard all entries with same result as REQ-032; reset takes priority over flush and all fires.

Verification
REQ-036 DEPTH=3, fill 0xA,0xB,0xC with deq_ready=0 -> count 1,2,3, enq_ready=0 after third, almost_full=1 at count 2; drain -> 0xA,0xB,0xC in order, pointers wrap to 0.
REQ-037 DEPTH=3 full, PIPE=1, enq_valid=deq_ready=1 with 0xD -> deq 0xA, enq accepted, count stays 3; PIPE=0 same stimulus -> enq_ready=0, count 2.
REQ-038 FLOW=1, empty, enq 0x55 with deq_ready=1 -> deq_valid=1, deq_bits=0x55 same cycle, count stays 0; deq_ready=0 -> stored, count 1.
REQ-039 Queue holding 2 entries, flush=1 with enq_valid=1 -> next cycle count=0, deq_valid=0, dropped entry never emerges.
REQ-040 Reset asserted with count=2 and concurrent enq/deq -> next cycle count=0, enq_ready=1, deq_valid=0.
REQ-041 Random valid/ready, 10k cycles, DEPTH in {1,3,4,5}, all FLOW/PIPE combos -> scoreboard matches, count equals model, no overflow.
